sram_axil_slave: RTL and testbench
==================================

SRAM_AXIL_SLAVE -- requirements
Module: sram_axil_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, backing-store depth in words (power of two).
REQ-004 SHALL have parameter LATENCY, default 1, fixed access latency in cycles, legal range 1..15.
REQ-005 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous and active-high.
REQ-006 SHALL have read-address ports: araddr input ADDR_WIDTH; arvalid input 1; arready output 1.
REQ-007 SHALL have read-data ports: rdata output DATA_WIDTH; rresp output 2; rvalid output 1; rready input 1.
REQ-008 SHALL have write-address ports: awaddr input ADDR_WIDTH; awvalid input 1; awready output 1.
REQ-009 SHALL have write-data ports: wdata input DATA_WIDTH; wstrb input DATA_WIDTH/8, byte enables; wvalid input 1; wready output 1.
REQ-010 SHALL have write-response ports: bresp output 2; bvalid output 1; bready input 1.

Function
REQ-011 SHALL index words by addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
REQ-012 SHALL treat addr >= DEPTH_WORDS*4 as out of range: rresp/bresp = 2'b11, rdata = 0, no store update; otherwise resp = 2'b00.
REQ-013 SHALL run read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE; arready = 1 only in R_IDLE.
REQ-014 SHALL capture araddr on arvalid & arready (cycle T) and assert rvalid at cycle T+latency with rdata/rresp stable.
REQ-015 SHALL hold rvalid, rdata, rresp unchanged until rready; on rvalid & rready return to R_IDLE, arready high the following cycle.
REQ-016 SHALL run write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE; awready and wready are independent and each drops after its own handshake.
REQ-017 SHALL accept AW and W in either order or the same cycle; W_WAIT entered on the cycle both are captured (cycle T).
REQ-018 SHALL commit write at cycle T+latency, updating only bytes with wstrb[i] = 1, and assert bvalid that same cycle.
REQ-019 SHALL hold bvalid/bresp until bready; on handshake return to W_IDLE with awready = wready = 1 next cycle.
REQ-020 SHALL return old data when a read sample and a write commit hit the same word in the same cycle (read-before-write).
REQ-021 SHALL operate read and write FSMs concurrently without mutual stalls.
REQ-022 SHALL implement latency with a per-channel down-counter loaded at acceptance; counter width 4 bits.

Reset
REQ-023 SHALL on rst = 1 at a clk edge force: arready = 1, awready = 1, wready = 1, rvalid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0, both FSMs idle, counters 0.
REQ-024 SHALL abort in-flight transactions on reset; uncommitted writes are dropped, committed data retained.
REQ-025 SHALL NOT reset backing-store contents.

Configuration
REQ-026 SHALL with SRAM_RAND_DELAY_EN defined, contain an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advancing every cycle); per-transaction latency = lfsr[2:0]+1 sampled at acceptance (1..8), independent per channel.
REQ-027 SHALL without SRAM_RAND_DELAY_EN use LATENCY for every transaction and contain no LFSR.

Verification
REQ-028 SHALL cover: write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read 0x10 -> rdata=0xDEADBEEF, rresp=0, rvalid exactly LATENCY cycles after AR handshake.
REQ-029 SHALL cover: after REQ-028, write 0x10 wdata=0x00000055 wstrb=4'b0001 -> read returns 0xDEADBE55.
REQ-030 SHALL cover: W presented 3 cycles before AW -> wready drops after W handshake, bvalid LATENCY cycles after AW handshake, bresp=0.
REQ-031 SHALL cover: rready held 0 for 5 cycles -> rvalid/rdata stable all 5 cycles, arready=0 until cycle after rready.
REQ-032 SHALL cover: read of DEPTH_WORDS*4 -> rresp=2'b11, rdata=0; write there -> bresp=2'b11, store unchanged.
REQ-033 SHALL cover: rst asserted in W_WAIT -> bvalid=0, all readies 1 next cycle, target word holds pre-write value.

Source files
------------

// File: rtl/sram_axil_slave.sv
// AXI4-Lite slave over a word-addressed backing store with fixed or LFSR-randomised access latency.
// Optional feature macro: SRAM_RAND_DELAY_EN (per-transaction latency 1..8 taken from an 8-bit LFSR).
module sram_axil_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  // state | meaning: *_IDLE accept request, *_WAIT count down latency, *_RESP hold response until ready
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  r_state_t              r_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [IDX_W-1:0]      ridx_q;
  logic                  r_oor_q;
  logic [3:0]            rcnt_q;

  w_state_t              w_state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [IDX_W-1:0]      widx_q;
  logic                  w_oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [3:0]            wcnt_q;

  logic [3:0] rd_lat_d;
  logic [3:0] wr_lat_d;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; free-running so each channel samples a fresh value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign rd_lat_d = {1'b0, lfsr_q[2:0]};
  assign wr_lat_d = {1'b0, lfsr_q[2:0]};
`else
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  assign rd_lat_d = LAT_LOAD;
  assign wr_lat_d = LAT_LOAD;
`endif

  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic aw_have;
  logic w_have;
  logic wr_commit;

  assign ar_hs   = arvalid & arready_q & (r_state_q == R_IDLE);
  assign aw_hs   = awvalid & awready_q & (w_state_q == W_IDLE);
  assign w_hs    = wvalid & wready_q & (w_state_q == W_IDLE);
  assign aw_have = aw_hs | ~awready_q;
  assign w_have  = w_hs | ~wready_q;

  // Counter loads latency-1, so the access happens exactly LATENCY edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      ridx_q    <= '0;
      r_oor_q   <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            ridx_q    <= araddr[IDX_W+1:2];
            r_oor_q   <= out_of_range(araddr);
            rcnt_q    <= rd_lat_d;
            arready_q <= 1'b0;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt_q == 4'd0) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= r_oor_q ? '0 : mem_q[ridx_q];
            rresp_q   <= r_oor_q ? 2'b11 : 2'b00;
            r_state_q <= R_RESP;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // awready/wready double as "not yet captured" flags while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      widx_q    <= '0;
      w_oor_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            widx_q    <= awaddr[IDX_W+1:2];
            w_oor_q   <= out_of_range(awaddr);
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= wdata;
            wstrb_q  <= wstrb;
            wready_q <= 1'b0;
          end
          if (aw_have && w_have) begin
            wcnt_q    <= wr_lat_d;
            w_state_q <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt_q == 4'd0) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= w_oor_q ? 2'b11 : 2'b00;
            w_state_q <= W_RESP;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_commit = (w_state_q == W_WAIT) && (wcnt_q == 4'd0) && !w_oor_q && !rst;

  // Store is never reset; nonblocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) begin
          mem_q[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_sram_axil_slave.sv
// Scoreboard bench for sram_axil_slave: drivers push expected responses, negedge monitors pop and compare.
module tb_sram_axil_slave;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;

  sram_axil_slave #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          t;
  } exp_t;

  exp_t rq[$];
  exp_t bq[$];

  // Reference store: word index -> contents, updated with byte-enable arithmetic.
  logic [31:0] model [int];

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'(DEPTH * 4);
  endfunction

  bit hold_r = 1'b0;
  always @(posedge clk) begin
    #1;
    rready = !hold_r && ($urandom_range(0, 3) != 0);
    bready = ($urandom_range(0, 2) != 0);
  end

  bit          r_act = 1'b0, r_after = 1'b0, b_act = 1'b0, b_after = 1'b0;
  logic [31:0] r_hd;
  logic [1:0]  r_hr, b_hr;
  int          r_done = 0, b_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      r_act = 1'b0; r_after = 1'b0; b_act = 1'b0; b_after = 1'b0;
    end else begin
      if (r_after) begin
        check("arready_after_r", {31'b0, arready}, 32'd1);
        check("rvalid_after_r", {31'b0, rvalid}, 32'd0);
        r_after = 1'b0;
      end
      if (rvalid) begin
        check("arready_low_in_resp", {31'b0, arready}, 32'd0);
        if (!r_act) begin
          r_act = 1'b1; r_hd = rdata; r_hr = rresp;
          if (rq.size() == 0) fail_now("r_unexpected");
          else begin
            check("r_time", cyc, rq[0].t);
            check("rdata", rdata, rq[0].data);
            check("rresp", {30'b0, rresp}, {30'b0, rq[0].resp});
          end
        end else begin
          check("rdata_hold", rdata, r_hd);
          check("rresp_hold", {30'b0, rresp}, {30'b0, r_hr});
        end
        if (rready) begin
          if (rq.size() > 0) void'(rq.pop_front());
          r_act = 1'b0; r_after = 1'b1; r_done++;
        end
      end else if (r_act) begin
        fail_now("rvalid_dropped");
        r_act = 1'b0;
      end

      if (b_after) begin
        check("awready_after_b", {31'b0, awready}, 32'd1);
        check("wready_after_b", {31'b0, wready}, 32'd1);
        b_after = 1'b0;
      end
      if (bvalid) begin
        check("awready_low_in_b", {31'b0, awready}, 32'd0);
        if (!b_act) begin
          b_act = 1'b1; b_hr = bresp;
          if (bq.size() == 0) fail_now("b_unexpected");
          else begin
            check("b_time", cyc, bq[0].t);
            check("bresp", {30'b0, bresp}, {30'b0, bq[0].resp});
          end
        end else begin
          check("bresp_hold", {30'b0, bresp}, {30'b0, b_hr});
        end
        if (bready) begin
          if (bq.size() > 0) void'(bq.pop_front());
          b_act = 1'b0; b_after = 1'b1; b_done++;
        end
      end else if (b_act) begin
        fail_now("bvalid_dropped");
        b_act = 1'b0;
      end
    end
  end

  task automatic rd_raw(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n = 0;
    int h;
    int d0 = r_done;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      fail_now("ar_timeout");
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    h = cyc; arvalid = 1'b0; araddr = $urandom;
    check("arready_drop", {31'b0, arready}, 32'd0);
    rq.push_back('{ed, er, h + LAT});
    n = 0;
    while (r_done == d0 && n < 100) begin @(negedge clk); n++; end
    if (r_done == d0) fail_now("r_timeout");
  endtask

  task automatic rd(input logic [31:0] a);
    if (in_range(a)) rd_raw(a, model[int'(a >> 2)], 2'b00);
    else             rd_raw(a, 32'h0, 2'b11);
  endtask

  // lead > 0: W offered that many cycles before AW; lead < 0: AW first.
  task automatic wr_raw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int lead, input logic [1:0] er);
    int aw_c = 0, w_c = 0;
    int d0 = b_done;
    int n = 0;
    fork
      begin
        int na = 0;
        @(posedge clk); #1;
        repeat ((lead > 0) ? lead : 0) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        while (!awready && na < 50) begin @(posedge clk); #1; na++; end
        if (!awready) fail_now("aw_timeout");
        @(posedge clk); #1;
        aw_c = cyc; awvalid = 1'b0; awaddr = $urandom;
        check("awready_drop", {31'b0, awready}, 32'd0);
      end
      begin
        int nw = 0;
        @(posedge clk); #1;
        repeat ((lead < 0) ? -lead : 0) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        while (!wready && nw < 50) begin @(posedge clk); #1; nw++; end
        if (!wready) fail_now("w_timeout");
        @(posedge clk); #1;
        w_c = cyc; wvalid = 1'b0; wdata = $urandom;
        check("wready_drop", {31'b0, wready}, 32'd0);
      end
    join
    bq.push_back('{32'h0, er, ((aw_c > w_c) ? aw_c : w_c) + LAT});
    while (b_done == d0 && n < 100) begin @(negedge clk); n++; end
    if (b_done == d0) fail_now("b_timeout");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    if (in_range(a)) begin
      logic [31:0] w;
      int k = int'(a >> 2);
      w = model.exists(k) ? model[k] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[k] = w;
      wr_raw(a, d, s, lead, 2'b00);
    end else begin
      wr_raw(a, d, s, lead, 2'b11);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old, nd, a;
    int n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready", {31'b0, wready}, 32'd1);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", {30'b0, rresp}, 32'd0);
    check("rst_bresp", {30'b0, bresp}, 32'd0);
    rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) wr(32'(w * 4), $urandom, 4'hF, 0);

    wr(32'h10, 32'hDEADBEEF, 4'hF, 0);
    rd_raw(32'h10, 32'hDEADBEEF, 2'b00);
    wr(32'h10, 32'h00000055, 4'b0001, 0);
    rd_raw(32'h10, 32'hDEADBE55, 2'b00);

    wr(32'h20, $urandom, 4'hF, 3);
    wr(32'h24, $urandom, 4'hF, -2);
    rd(32'h20);

    hold_r = 1'b1;
    fork
      rd(32'h10);
      begin
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        hold_r = 1'b0;
      end
    join

    rd_raw(32'(DEPTH * 4), 32'h0, 2'b11);
    wr(32'(DEPTH * 4), 32'hA5A5A5A5, 4'hF, 0);
    rd(32'h0);
    rd(32'hFFFF_FFF0);

    old = model[5];
    nd  = $urandom;
    fork
      wr(32'h14, nd, 4'hF, 0);
      rd_raw(32'h14, old, 2'b00);
    join
    rd(32'h14);

    repeat (2) @(posedge clk);
    #1;
    awaddr = 32'h20; awvalid = 1'b1;
    wdata = ~model[8]; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_bvalid", {31'b0, bvalid}, 32'd0);
    check("rstw_awready", {31'b0, awready}, 32'd1);
    check("rstw_wready", {31'b0, wready}, 32'd1);
    check("rstw_arready", {31'b0, arready}, 32'd1);
    repeat (LAT + 2) @(posedge clk);
    check("rstw_no_late_b", {31'b0, bvalid}, 32'd0);
    rd(32'h20);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else                           a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
      else                           rd(a);
    end

    repeat (4) @(posedge clk);
    if (rq.size() != 0) fail_now("r_queue_not_empty");
    if (bq.size() != 0) fail_now("b_queue_not_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
